// File: rtl/ai_knn_voter.sv
// K-nearest-neighbour voter: tallies class votes over the first K words of a sorted
// frame, then scans one class per cycle to pick the winner (most votes, then nearest).
module ai_knn_voter #(
  parameter int SIZE        = 8,
  parameter int K           = 5,
  parameter int NUM_CLASSES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic [31:0] data_in,
  input  logic        data_rdy,
  input  logic        sort_ready,
  output logic [7:0]  class_out,
  output logic [3:0]  votes_out,
  output logic [23:0] class_dist,
  output logic        no_match,
  output logic        result_valid,
  output logic        busy,
  output logic        overrun
);

  localparam int IW = $clog2(SIZE + 1);
  localparam int CW = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
  localparam logic [23:0] NO_DIST = 24'hFFFFFF;

  typedef enum logic [1:0] {COLLECT, SCAN, OUTPUT} state_t;
  state_t state, state_nxt;

  logic [3:0]    votes     [NUM_CLASSES];
  logic [23:0]   best_dist [NUM_CLASSES];
  logic [IW-1:0] idx;
  logic [CW-1:0] scan_idx;
  logic [3:0]    win_votes;
  logic [23:0]   win_dist;
  logic [7:0]    win_label;

  logic [7:0]    label;
  logic [23:0]   score;
  logic          label_ok, vote_ok, scan_last;
  logic [3:0]    cand_votes, nxt_votes;
  logic [23:0]   cand_dist, nxt_dist;
  logic [7:0]    nxt_label;
  logic          take;

  assign label     = data_in[31:24];
  assign score     = data_in[23:0];
  assign label_ok  = {1'b0, label} < 9'(NUM_CLASSES);
  assign vote_ok   = data_rdy && (idx < IW'(K)) && label_ok && (score != NO_DIST);
  assign scan_last = (scan_idx == CW'(NUM_CLASSES - 1));

  assign busy         = (state != COLLECT);
  assign result_valid = (state == OUTPUT);

  always_ff @(posedge clk) begin
    if (rst || init) state <= COLLECT;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: if (sort_ready) state_nxt = SCAN;
      SCAN:    if (scan_last)  state_nxt = OUTPUT;
      OUTPUT:  state_nxt = COLLECT;
      default: state_nxt = COLLECT;
    endcase
  end

  // Candidate wins on more votes, or equal nonzero votes at a strictly smaller distance;
  // ascending scan therefore keeps the lower label on a full tie.
  always_comb begin
    cand_votes = votes[scan_idx];
    cand_dist  = best_dist[scan_idx];
    take       = (cand_votes > win_votes) ||
                 ((cand_votes == win_votes) && (cand_votes != 4'd0) && (cand_dist < win_dist));
    nxt_votes  = take ? cand_votes   : win_votes;
    nxt_dist   = take ? cand_dist    : win_dist;
    nxt_label  = take ? 8'(scan_idx) : win_label;
  end

  always_ff @(posedge clk) begin
    if (rst)                                               overrun <= 1'b0;
    else if (!init && busy && (data_rdy || sort_ready))    overrun <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst || init) begin
      for (int c = 0; c < NUM_CLASSES; c++) begin
        votes[c]     <= 4'd0;
        best_dist[c] <= NO_DIST;
      end
      idx        <= '0;
      scan_idx   <= '0;
      win_votes  <= 4'd0;
      win_dist   <= NO_DIST;
      win_label  <= 8'hFF;
      class_out  <= 8'd0;
      votes_out  <= 4'd0;
      class_dist <= 24'd0;
      no_match   <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          scan_idx  <= '0;
          win_votes <= 4'd0;
          win_dist  <= NO_DIST;
          win_label <= 8'hFF;
          if (data_rdy && (idx < IW'(SIZE))) idx <= idx + 1'b1;
          if (vote_ok) begin
            votes[label[CW-1:0]] <= votes[label[CW-1:0]] + 4'd1;
            if (score < best_dist[label[CW-1:0]]) best_dist[label[CW-1:0]] <= score;
          end
        end
        SCAN: begin
          win_votes <= nxt_votes;
          win_dist  <= nxt_dist;
          win_label <= nxt_label;
          scan_idx  <= scan_idx + 1'b1;
          // Results land here so they are already visible in the OUTPUT cycle.
          if (scan_last) begin
            no_match   <= (nxt_votes == 4'd0);
            votes_out  <= nxt_votes;
            class_out  <= (nxt_votes == 4'd0) ? 8'hFF   : nxt_label;
            class_dist <= (nxt_votes == 4'd0) ? NO_DIST : nxt_dist;
          end
        end
        OUTPUT: begin
          for (int c = 0; c < NUM_CLASSES; c++) begin
            votes[c]     <= 4'd0;
            best_dist[c] <= NO_DIST;
          end
          idx <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ai_knn_voter.sv
// Directed bench for ai_knn_voter: a K=5 and a K=4 instance share one input stream.
module tb_ai_knn_voter;
  logic        clk = 1'b0;
  logic        rst, init, data_rdy, sort_ready;
  logic [31:0] data_in;

  logic [7:0]  cls5, cls4;
  logic [3:0]  vot5, vot4;
  logic [23:0] dst5, dst4;
  logic        nm5, nm4, rv5, rv4, busy5, busy4, ovr5, ovr4;

  int total = 0, passed = 0, failed = 0;
  int lat;
  logic [31:0] fr [8];

  always #5 clk = ~clk;

  ai_knn_voter #(.SIZE(8), .K(5), .NUM_CLASSES(16)) dut5 (
    .clk(clk), .rst(rst), .init(init), .data_in(data_in), .data_rdy(data_rdy),
    .sort_ready(sort_ready), .class_out(cls5), .votes_out(vot5), .class_dist(dst5),
    .no_match(nm5), .result_valid(rv5), .busy(busy5), .overrun(ovr5));

  ai_knn_voter #(.SIZE(8), .K(4), .NUM_CLASSES(16)) dut4 (
    .clk(clk), .rst(rst), .init(init), .data_in(data_in), .data_rdy(data_rdy),
    .sort_ready(sort_ready), .class_out(cls4), .votes_out(vot4), .class_dist(dst4),
    .no_match(nm4), .result_valid(rv4), .busy(busy4), .overrun(ovr4));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives n words ending with sort_ready on the last; returns at the negedge of cycle T+1.
  task automatic send_frame(input int n);
    if (n == 0) begin
      @(negedge clk); sort_ready = 1'b1;
    end
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      data_in = fr[i]; data_rdy = 1'b1; sort_ready = (i == n - 1);
    end
    @(negedge clk);
    data_rdy = 1'b0; sort_ready = 1'b0; data_in = '0;
  endtask

  task automatic wait_result(input int start);
    lat = start;
    while (!rv5 && lat < 40) begin
      @(negedge clk); lat++;
    end
  endtask

  task automatic chk_res(input string tag, input logic [7:0] c5, input logic [3:0] v5,
                         input logic [23:0] d5, input logic [7:0] c4, input logic [3:0] v4,
                         input logic [23:0] d4);
    chk({tag, "_valid"}, {31'd0, rv5}, 32'd1);
    chk({tag, "_valid4"}, {31'd0, rv4}, 32'd1);
    chk({tag, "_lat"}, lat, 32'd17);
    chk({tag, "_class"}, cls5, c5);
    chk({tag, "_votes"}, vot5, v5);
    chk({tag, "_dist"}, dst5, d5);
    chk({tag, "_nomatch"}, nm5, v5 == 4'd0);
    chk({tag, "_class4"}, cls4, c4);
    chk({tag, "_votes4"}, vot4, v4);
    chk({tag, "_dist4"}, dst4, d4);
    chk({tag, "_nomatch4"}, nm4, v4 == 4'd0);
    @(negedge clk);
    chk({tag, "_strobe_end"}, {31'd0, rv5}, 32'd0);
    chk({tag, "_idle"}, {31'd0, busy5}, 32'd0);
    chk({tag, "_hold"}, cls5, c5);
  endtask

  task automatic load_s1();
    logic [7:0] l [8] = '{8'd3, 8'd3, 8'd5, 8'd3, 8'd5, 8'd7, 8'd7, 8'd7};
    for (int i = 0; i < 8; i++) fr[i] = {l[i], 24'(10 * (i + 1))};
  endtask

  initial begin
    rst = 1'b1; init = 1'b0; data_rdy = 1'b0; sort_ready = 1'b0; data_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_class", cls5, 0);
    chk("rst_dist", dst5, 0);
    chk("rst_flags", {rv5, busy5, ovr5, nm5, vot5}, 0);
    chk("rst_flags4", {rv4, busy4, ovr4, nm4, vot4, cls4}, 0);
    rst = 1'b0;

    // 1: majority vote
    load_s1();
    send_frame(8);
    chk("s1_busy", {31'd0, busy5}, 32'd1);
    wait_result(1);
    chk_res("s1", 8'd3, 4'd3, 24'd10, 8'd3, 4'd3, 24'd10);

    // 2: distance tie-break for K=4; a fifth word tips K=5 to label 2
    fr[0] = {8'd6, 24'd10}; fr[1] = {8'd2, 24'd20}; fr[2] = {8'd6, 24'd30};
    fr[3] = {8'd2, 24'd40}; fr[4] = {8'd2, 24'd50};
    send_frame(5);
    wait_result(1);
    chk_res("s2", 8'd2, 4'd3, 24'd20, 8'd6, 4'd2, 24'd10);

    // 3: every score invalid
    for (int i = 0; i < 8; i++) fr[i] = {8'(i), 24'hFFFFFF};
    send_frame(8);
    wait_result(1);
    chk_res("s3", 8'hFF, 4'd0, 24'hFFFFFF, 8'hFF, 4'd0, 24'hFFFFFF);

    // 4: out-of-range labels ignored
    fr[0] = {8'd20, 24'd1}; fr[1] = {8'd20, 24'd2}; fr[2] = {8'd20, 24'd3};
    fr[3] = {8'd4, 24'd4};  fr[4] = {8'd9, 24'd5};
    send_frame(5);
    wait_result(1);
    chk_res("s4", 8'd4, 4'd1, 24'd4, 8'd4, 4'd1, 24'd4);

    // sort_ready with no beats
    send_frame(0);
    wait_result(1);
    chk_res("empty", 8'hFF, 4'd0, 24'hFFFFFF, 8'hFF, 4'd0, 24'hFFFFFF);

    // 5: overrun during SCAN leaves the result untouched
    load_s1();
    send_frame(8);
    @(negedge clk); @(negedge clk);
    data_in = {8'd7, 24'd1}; data_rdy = 1'b1;
    @(negedge clk);
    data_rdy = 1'b0; data_in = '0;
    chk("s5_overrun", {31'd0, ovr5}, 32'd1);
    wait_result(4);
    chk_res("s5", 8'd3, 4'd3, 24'd10, 8'd3, 4'd3, 24'd10);
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    chk("s5_init_ovr", {31'd0, ovr5}, 32'd1);
    chk("s5_init_class", cls5, 0);

    // 6: reset mid-SCAN, then a clean frame
    load_s1();
    send_frame(8);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("s6_rst_outs", {cls5, vot5, nm5, rv5, busy5, ovr5}, 0);
    chk("s6_rst_dist", dst5, 0);
    begin
      int seen = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (rv5 || rv4) seen++;
      end
      chk("s6_no_valid", seen, 0);
    end
    send_frame(8);
    wait_result(1);
    chk_res("s6", 8'd3, 4'd3, 24'd10, 8'd3, 4'd3, 24'd10);
    chk("s6_ovr_clear", {31'd0, ovr5}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
